// File: rtl/udp_tx_scheduler_pkg.sv
// Shared encodings for the UDP/ARP transmit scheduler: launch sources,
// FSM states and the source-to-trigger mapping.
package udp_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_AD    = 2'd1,
    SRC_MOTOR = 2'd2,
    SRC_ARP   = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } state_e;

  // One-hot launch vector {arp, motor, ad}; SRC_NONE maps to no launch.
  function automatic logic [2:0] src_to_trig(src_e src);
    case (src)
      SRC_AD:    return 3'b001;
      SRC_MOTOR: return 3'b010;
      SRC_ARP:   return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// Request, end-of-frame and launch signals between the frame sources,
// the shared transmitter and the scheduler.
interface udp_tx_scheduler_if #(
  parameter int TCNT_W = 16,
  parameter int DCNT_W = 8
);
  logic              AD_FRAME_RDY;
  logic              MOTOR_REQ;
  logic              ARP_REQ;
  logic              PC_ADDR_VALID;
  logic              UDP_LAST;
  logic              ARP_LAST;
  logic              TRIG_ETH_TX;
  logic              TRIG_MOTOR_STATE;
  logic              TRIG_TX_ARP;
  logic              TX_BUSY;
  logic [1:0]        CUR_SRC;
  logic              TIMEOUT_ERR;
  logic [TCNT_W-1:0] TIMEOUT_CNT;
  logic [DCNT_W-1:0] MOTOR_DROP_CNT;

  modport master (
    output AD_FRAME_RDY, MOTOR_REQ, ARP_REQ, PC_ADDR_VALID, UDP_LAST, ARP_LAST,
    input  TRIG_ETH_TX, TRIG_MOTOR_STATE, TRIG_TX_ARP, TX_BUSY, CUR_SRC,
           TIMEOUT_ERR, TIMEOUT_CNT, MOTOR_DROP_CNT
  );

  modport slave (
    input  AD_FRAME_RDY, MOTOR_REQ, ARP_REQ, PC_ADDR_VALID, UDP_LAST, ARP_LAST,
    output TRIG_ETH_TX, TRIG_MOTOR_STATE, TRIG_TX_ARP, TX_BUSY, CUR_SRC,
           TIMEOUT_ERR, TIMEOUT_CNT, MOTOR_DROP_CNT
  );
endinterface

// File: rtl/udp_tx_scheduler_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK_125M,
  input  logic             SYS_RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge CLK_125M) begin
    if (SYS_RST || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Serialises AD, motor-state and ARP frame launches onto one transmit path,
// with request latching, AD burst limiting, inter-frame gap and a watchdog.
module udp_tx_scheduler
  import udp_tx_scheduler_pkg::*;
#(
  parameter int IFG_CYCLES     = 12,
  parameter int AD_BURST_MAX   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TCNT_W         = 16,
  parameter int DCNT_W         = 8
) (
  input logic               CLK_125M,
  input logic               SYS_RST,
  udp_tx_scheduler_if.slave tx
);

  localparam int WDOG_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W    = $clog2(IFG_CYCLES + 2);
  localparam int STREAK_W = $clog2(AD_BURST_MAX + 1);

  state_e              state_q, state_d;
  src_e                src_q, winner;
  logic [2:0]          trig_q;
  logic                busy_q, terr_q;
  logic                motor_pend_q, arp_pend_q;
  logic [STREAK_W-1:0] streak_q;
  logic [WDOG_W-1:0]   wdog_q;
  logic [GAP_W-1:0]    gap_q;
  logic                streak_sat, frame_done, wdog_expire, drop_inc;
  logic [TCNT_W-1:0]   timeout_cnt;
  logic [DCNT_W-1:0]   drop_cnt;

  assign streak_sat = (streak_q >= STREAK_W'(AD_BURST_MAX));
  assign drop_inc   = tx.MOTOR_REQ && motor_pend_q && (winner != SRC_MOTOR);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    winner      = SRC_NONE;
    state_d     = state_q;
    frame_done  = 1'b0;
    wdog_expire = 1'b0;

    if (state_q == ST_IDLE) begin
      if (arp_pend_q) begin
        winner = SRC_ARP;
      end else if (tx.PC_ADDR_VALID && motor_pend_q && (streak_sat || !tx.AD_FRAME_RDY)) begin
        winner = SRC_MOTOR;
      end else if (tx.PC_ADDR_VALID && tx.AD_FRAME_RDY) begin
        winner = SRC_AD;
      end
    end

    // The trigger cycle itself never completes a frame.
    if (state_q == ST_WAIT_DONE) begin
      frame_done  = (trig_q == 3'b000) &&
                    ((src_q == SRC_ARP) ? tx.ARP_LAST : tx.UDP_LAST);
      wdog_expire = !frame_done && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
    end

    case (state_q)
      ST_IDLE: begin
        if (winner != SRC_NONE) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (frame_done || wdog_expire) state_d = (IFG_CYCLES > 1) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(2)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_125M) begin
    if (SYS_RST) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_NONE;
      trig_q       <= '0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      motor_pend_q <= 1'b0;
      arp_pend_q   <= 1'b0;
      streak_q     <= '0;
      wdog_q       <= '0;
      gap_q        <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= src_to_trig(winner);
      terr_q  <= wdog_expire;

      // A request in the grant cycle re-arms its latch rather than being lost.
      motor_pend_q <= tx.MOTOR_REQ | (motor_pend_q & (winner != SRC_MOTOR));
      arp_pend_q   <= tx.ARP_REQ   | (arp_pend_q   & (winner != SRC_ARP));

      if (winner != SRC_NONE) begin
        src_q  <= winner;
        busy_q <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        src_q  <= SRC_NONE;
        busy_q <= 1'b0;
      end

      wdog_q <= (state_q == ST_WAIT_DONE && state_d == ST_WAIT_DONE) ? wdog_q + 1'b1 : '0;

      if (frame_done || wdog_expire) begin
        gap_q <= GAP_W'(IFG_CYCLES);
      end else if (state_q == ST_GAP) begin
        gap_q <= gap_q - 1'b1;
      end

      // An AD grant counts toward the burst even when it also lands in an
      // otherwise-clearing idle cycle.
      if (winner == SRC_AD) begin
        if (!streak_sat) streak_q <= streak_q + 1'b1;
      end else if (winner == SRC_MOTOR || (state_q == ST_IDLE && !motor_pend_q)) begin
        streak_q <= '0;
      end
    end
  end

  sat_counter #(.WIDTH(TCNT_W)) u_timeout_cnt (
    .CLK_125M (CLK_125M),
    .SYS_RST  (SYS_RST),
    .inc      (wdog_expire),
    .clr      (1'b0),
    .count    (timeout_cnt)
  );

  sat_counter #(.WIDTH(DCNT_W)) u_drop_cnt (
    .CLK_125M (CLK_125M),
    .SYS_RST  (SYS_RST),
    .inc      (drop_inc),
    .clr      (1'b0),
    .count    (drop_cnt)
  );

  assign tx.TRIG_ETH_TX      = trig_q[0];
  assign tx.TRIG_MOTOR_STATE = trig_q[1];
  assign tx.TRIG_TX_ARP      = trig_q[2];
  assign tx.TX_BUSY          = busy_q;
  assign tx.CUR_SRC          = src_q;
  assign tx.TIMEOUT_ERR      = terr_q;
  assign tx.TIMEOUT_CNT      = timeout_cnt;
  assign tx.MOTOR_DROP_CNT   = drop_cnt;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: a timeline-based reference model
// predicts launches, timeouts and per-cycle status; a monitor compares.
module tb_udp_tx_scheduler;

  localparam int IFG    = 12;
  localparam int BURST  = 4;
  localparam int TMO    = 4096;
  localparam int TCNT_W = 16;
  localparam int DCNT_W = 8;
  localparam int SRC_A  = 1;
  localparam int SRC_M  = 2;
  localparam int SRC_R  = 3;

  typedef struct { int src; int cyc; } trig_t;
  typedef struct { bit busy; int src; int drop; int tcnt; } snap_t;

  logic CLK_125M = 1'b0;
  logic SYS_RST;
  always #4 CLK_125M = ~CLK_125M;

  udp_tx_scheduler_if #(.TCNT_W(TCNT_W), .DCNT_W(DCNT_W)) tx ();

  udp_tx_scheduler #(
    .IFG_CYCLES(IFG), .AD_BURST_MAX(BURST), .TIMEOUT_CYCLES(TMO),
    .TCNT_W(TCNT_W), .DCNT_W(DCNT_W)
  ) dut (
    .CLK_125M (CLK_125M),
    .SYS_RST  (SYS_RST),
    .tx       (tx)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge CLK_125M) cyc <= cyc + 1;

  trig_t exp_trig[$];
  int    exp_tmo[$];
  snap_t exp_snap[int];
  trig_t trig_log[$];
  int    tmo_log[$];

  // Reference model: frame timeline expressed as cycle numbers.
  bit m_mp, m_ap, m_open;
  int m_streak, m_src, m_trig, m_idle_at, m_drop, m_tcnt;

  // Stimulus levels and transmitter behaviour (0 silent, 1 fixed length, 2 random).
  bit ad_lvl, pcv_lvl;
  int resp_mode, resp_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_step(input int c, input bit ad, input bit pcv, input bit mreq,
                                     input bit areq, input bit ul, input bit al, input bit rst);
    int g;
    bit busy_n;
    if (rst) begin
      m_mp = 0; m_ap = 0; m_open = 0; m_streak = 0; m_src = 0;
      m_idle_at = c + 1; m_drop = 0; m_tcnt = 0;
    end else begin
      g = 0;
      if (!m_open && c >= m_idle_at) begin
        if (m_ap) g = SRC_R;
        else if (pcv && m_mp && (m_streak >= BURST || !ad)) g = SRC_M;
        else if (pcv && ad) g = SRC_A;
        if (g == SRC_A) m_streak = (m_streak < BURST) ? m_streak + 1 : BURST;
        else if (g == SRC_M || !m_mp) m_streak = 0;
        if (g != 0) begin
          exp_trig.push_back('{g, c + 1});
          m_open = 1; m_src = g; m_trig = c + 1;
        end
      end else if (m_open) begin
        if (c > m_trig && ((m_src == SRC_R) ? al : ul)) begin
          m_open = 0;
          m_idle_at = c + ((IFG > 1) ? IFG : 1);
        end else if (c - m_trig == TMO - 1) begin
          exp_tmo.push_back(c + 1);
          if (m_tcnt < 65535) m_tcnt++;
          m_open = 0;
          m_idle_at = c + ((IFG > 1) ? IFG : 1);
        end
      end
      if (mreq && m_mp && g != SRC_M && m_drop < 255) m_drop++;
      m_mp = mreq || (m_mp && g != SRC_M);
      m_ap = areq || (m_ap && g != SRC_R);
    end
    busy_n = m_open || (c + 1 < m_idle_at);
    exp_snap[c + 1] = '{busy_n, busy_n ? m_src : 0, m_drop, m_tcnt};
  endfunction

  task automatic step(input bit mreq, input bit areq, input bit rst, input bit xul, input bit xal);
    bit ul, al, match;
    int c;
    @(posedge CLK_125M);
    #1;
    c = cyc; ul = xul; al = xal; match = 0;
    if (m_open && c >= m_trig) begin
      if (resp_mode == 1) begin
        match = (c == m_trig) || (c == m_trig + resp_len);
        if (c == m_trig + 5) begin
          if (m_src == SRC_R) ul = 1; else al = 1;
        end
      end else if (resp_mode == 2) begin
        match = ($urandom_range(0, 29) == 0);
      end
      if (match) begin
        if (m_src == SRC_R) al = 1; else ul = 1;
      end
    end
    SYS_RST          = rst;
    tx.AD_FRAME_RDY  = ad_lvl;
    tx.PC_ADDR_VALID = pcv_lvl;
    tx.MOTOR_REQ     = mreq;
    tx.ARP_REQ       = areq;
    tx.UDP_LAST      = ul;
    tx.ARP_LAST      = al;
    model_step(c, ad_lvl, pcv_lvl, mreq, areq, ul, al, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  function automatic int count_src(input int from, input int src);
    int n = 0;
    for (int i = from; i < trig_log.size(); i++) if (trig_log[i].src == src) n++;
    return n;
  endfunction

  // Monitor: compares status every modelled cycle and pops launch/timeout expectations.
  snap_t mon_e;
  int    mon_n, mon_src;
  trig_t mon_t;
  always @(negedge CLK_125M) begin
    if (exp_snap.exists(cyc)) begin
      mon_e = exp_snap[cyc];
      exp_snap.delete(cyc);
      check("tx_busy", tx.TX_BUSY, mon_e.busy);
      check("cur_src", tx.CUR_SRC, mon_e.src);
      check("motor_drop_cnt", tx.MOTOR_DROP_CNT, mon_e.drop);
      check("timeout_cnt", tx.TIMEOUT_CNT, mon_e.tcnt);
      mon_n = int'(tx.TRIG_ETH_TX) + int'(tx.TRIG_MOTOR_STATE) + int'(tx.TRIG_TX_ARP);
      if (mon_n != 0) begin
        mon_src = tx.TRIG_ETH_TX ? SRC_A : (tx.TRIG_MOTOR_STATE ? SRC_M : SRC_R);
        check("trig_onehot", mon_n, 1);
        trig_log.push_back('{mon_src, cyc});
        if (exp_trig.size() == 0) begin
          check("trig_unexpected", mon_src, 0);
        end else begin
          mon_t = exp_trig.pop_front();
          check("trig_src", mon_src, mon_t.src);
          check("trig_cycle", cyc, mon_t.cyc);
        end
      end
      if (tx.TIMEOUT_ERR !== 1'b0) begin
        tmo_log.push_back(cyc);
        if (exp_tmo.size() == 0) check("timeout_unexpected", tx.TIMEOUT_ERR, 0);
        else check("timeout_cycle", cyc, exp_tmo.pop_front());
      end
    end
  end

  int base, tbase, first_m;

  initial begin
    SYS_RST = 1'b1;
    tx.AD_FRAME_RDY = 0; tx.PC_ADDR_VALID = 0; tx.MOTOR_REQ = 0;
    tx.ARP_REQ = 0; tx.UDP_LAST = 0; tx.ARP_LAST = 0;
    ad_lvl = 0; pcv_lvl = 1; resp_mode = 1; resp_len = 50;
    m_idle_at = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // AD stream with a motor request arriving during the first frame.
    ad_lvl = 1;
    base = trig_log.size();
    for (int k = 0; k < 400; k++) step(k == 5, 0, 0, 0, 0);
    first_m = -1;
    for (int i = base; i < trig_log.size(); i++)
      if (trig_log[i].src == SRC_M && first_m < 0) first_m = i;
    check("ad_triggers_before_motor", first_m - base, 4);
    for (int i = base + 1; i < base + 4; i++) begin
      check("ad_src_in_burst", trig_log[i].src, SRC_A);
      check("ad_trigger_spacing", trig_log[i].cyc - trig_log[i - 1].cyc, 63);
    end
    check("motor_after_burst_spacing", trig_log[base + 4].cyc - trig_log[base + 3].cyc, 63);
    ad_lvl = 0;
    idle(150);

    // ARP and motor requested together; ARP first, motor one frame plus gap later.
    base = trig_log.size();
    step(1, 1, 0, 0, 0);
    idle(200);
    check("arp_motor_count", trig_log.size() - base, 2);
    check("arp_first", trig_log[base].src, SRC_R);
    check("motor_second", trig_log[base + 1].src, SRC_M);
    check("motor_after_arp", trig_log[base + 1].cyc - trig_log[base].cyc, 63);

    // Address unresolved: motor requests merge, then one launch once resolved.
    pcv_lvl = 0;
    base = trig_log.size();
    step(1, 0, 0, 0, 0); idle(4);
    step(1, 0, 0, 0, 0); idle(4);
    step(1, 0, 0, 0, 0); idle(20);
    check("no_launch_without_addr", trig_log.size() - base, 0);
    check("drop_cnt_after_three", tx.MOTOR_DROP_CNT, 2);
    pcv_lvl = 1;
    idle(150);
    check("single_motor_launch", count_src(base, SRC_M), 1);
    check("only_motor_launched", trig_log.size() - base, 1);

    // Silent transmitter: watchdog abort, then a regular frame after the gap.
    base = trig_log.size();
    tbase = tmo_log.size();
    resp_mode = 0;
    ad_lvl = 1;
    for (int i = 0; i < 4050; i++) step(0, 0, 0, 0, 0);
    resp_mode = 1;
    idle(100);
    ad_lvl = 0;
    idle(150);
    check("timeout_pulses", tmo_log.size() - tbase, 1);
    check("timeout_latency", tmo_log[tbase] - trig_log[base].cyc, TMO);
    check("regrant_after_timeout_gap", trig_log[base + 1].cyc - tmo_log[tbase], 12);
    check("timeout_cnt_after_abort", tx.TIMEOUT_CNT, 1);

    // Reset in the middle of a frame with a motor request pending.
    ad_lvl = 1;
    step(0, 0, 0, 0, 0);
    ad_lvl = 0;
    idle(10);
    step(1, 0, 0, 0, 0);
    idle(5);
    check("busy_before_reset", tx.TX_BUSY, 1);
    step(0, 0, 1, 0, 0);
    idle(1);
    check("busy_after_reset", tx.TX_BUSY, 0);
    check("src_after_reset", tx.CUR_SRC, 0);
    check("tcnt_after_reset", tx.TIMEOUT_CNT, 0);
    base = trig_log.size();
    idle(200);
    check("no_motor_after_reset", trig_log.size() - base, 0);

    // Randomised traffic against the model.
    resp_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ad_lvl = ~ad_lvl;
      if ($urandom_range(0, 49) == 0) pcv_lvl = ~pcv_lvl;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 1999) == 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
    end
    ad_lvl = 0;
    pcv_lvl = 1;
    idle(200);
    @(negedge CLK_125M);
    #1;
    check("launches_outstanding", exp_trig.size(), 0);
    check("timeouts_outstanding", exp_tmo.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
